food_manager: RTL and testbench

FOOD_MANAGER -- requirements
Module: food_manager

---
 rtl/snake_pkg.sv | 17 +
 rtl/lfsr16.sv | 28 ++
 rtl/food_manager.sv | 196 +++++++++++++++++++
 tb/tb_food_manager.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Playfield geometry defaults and the food spawn state encoding shared by
// the snake game blocks.
package snake_pkg;

    localparam int GRID_W_DEF = 40;
    localparam int GRID_H_DEF = 30;
    localparam int X_W_DEF    = 6;
    localparam int Y_W_DEF    = 5;
    localparam int LFSR_W     = 16;

    typedef enum logic [1:0] {
        SPAWN_IDLE  = 2'd0,
        SPAWN_PICK  = 2'd1,
        SPAWN_CHECK = 2'd2
    } spawn_state_e;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11, loaded from seed on reset.
module lfsr16
    import snake_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= seed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/food_manager.sv
// Food slot bookkeeping for the snake game: eat detection, saturating score,
// and a spawn FSM that refills empty slots with random free cells.
module food_manager
    import snake_pkg::*;
#(
    parameter int          GRID_W    = GRID_W_DEF,
    parameter int          GRID_H    = GRID_H_DEF,
    parameter int          X_W       = X_W_DEF,
    parameter int          Y_W       = Y_W_DEF,
    parameter int          N_FOOD    = 4,
    parameter int          SCORE_W   = 8,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [X_W-1:0]        head_x,
    input  logic [Y_W-1:0]        head_y,
    input  logic                  score_reset,
    output logic [X_W-1:0]        query_x,
    output logic [Y_W-1:0]        query_y,
    input  logic                  query_occupied,
    output logic [N_FOOD*X_W-1:0] food_x,
    output logic [N_FOOD*Y_W-1:0] food_y,
    output logic [N_FOOD-1:0]     food_valid,
    output logic                  eat,
    output logic [2:0]            eat_slot,
    output logic [SCORE_W-1:0]    score,
    output logic                  busy
);

    spawn_state_e       state_q, state_d;
    logic [LFSR_W-1:0]  lfsr;
    logic [X_W-1:0]     cand_x_q, cand_x_d;
    logic [Y_W-1:0]     cand_y_q, cand_y_d;
    logic [2:0]         target_q, target_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [N_FOOD-1:0]  hit;
    logic [N_FOOD-1:0]  clash;
    logic [2:0]         eat_idx;
    logic [2:0]         free_idx;
    logic               any_free;
    logic [X_W-1:0]     pick_x;
    logic [Y_W-1:0]     pick_y;
    logic               pick_ok;
    logic               reject;
    logic               accept;

    lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .seed (LFSR_SEED),
        .q    (lfsr)
    );

    assign pick_x  = lfsr[X_W-1:0];
    assign pick_y  = lfsr[X_W +: Y_W];
    assign pick_ok = (int'(pick_x) < GRID_W) && (int'(pick_y) < GRID_H);

    // Per-slot storage; eat clears and spawn sets never target the same slot
    // because the spawn target is always an invalid slot.
    for (genvar gi = 0; gi < N_FOOD; gi++) begin : g_slot
        localparam logic [2:0]     IDX   = 3'(gi);
        localparam logic           RST_V = (gi == 0);
        localparam logic [X_W-1:0] RST_X = (gi == 0) ? X_W'(GRID_W / 2) : '0;
        localparam logic [Y_W-1:0] RST_Y = (gi == 0) ? Y_W'(GRID_H / 2) : '0;

        logic           valid_q, valid_d;
        logic [X_W-1:0] x_q, x_d;
        logic [Y_W-1:0] y_q, y_d;

        always_comb begin
            valid_d = valid_q;
            x_d     = x_q;
            y_d     = y_q;
            if (eat && (eat_idx == IDX)) begin
                valid_d = 1'b0;
            end
            if (accept && (target_q == IDX)) begin
                valid_d = 1'b1;
                x_d     = cand_x_q;
                y_d     = cand_y_q;
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                valid_q <= RST_V;
                x_q     <= RST_X;
                y_q     <= RST_Y;
            end else begin
                valid_q <= valid_d;
                x_q     <= x_d;
                y_q     <= y_d;
            end
        end

        assign food_valid[gi]          = valid_q;
        assign food_x[gi*X_W +: X_W]   = x_q;
        assign food_y[gi*Y_W +: Y_W]   = y_q;
        assign hit[gi]   = valid_q && (x_q == head_x) && (y_q == head_y);
        assign clash[gi] = valid_q && (x_q == cand_x_q) && (y_q == cand_y_q);
    end

    always_comb begin
        eat_idx  = '0;
        free_idx = '0;
        for (int i = N_FOOD - 1; i >= 0; i--) begin
            if (hit[i]) begin
                eat_idx = 3'(i);
            end
            if (!food_valid[i]) begin
                free_idx = 3'(i);
            end
        end
    end

    assign eat      = |hit;
    assign eat_slot = eat_idx;
    assign any_free = ~&food_valid;
    assign reject   = query_occupied || ((cand_x_q == head_x) && (cand_y_q == head_y)) || (|clash);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= SPAWN_IDLE;
            cand_x_q <= '0;
            cand_y_q <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            cand_x_q <= cand_x_d;
            cand_y_q <= cand_y_d;
            target_q <= target_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cand_x_d = cand_x_q;
        cand_y_d = cand_y_q;
        target_d = target_q;
        case (state_q)
            SPAWN_IDLE: begin
                if (any_free) begin
                    target_d = free_idx;
                    state_d  = SPAWN_PICK;
                end
            end
            SPAWN_PICK: begin
                if (pick_ok) begin
                    cand_x_d = pick_x;
                    cand_y_d = pick_y;
                    state_d  = SPAWN_CHECK;
                end
            end
            SPAWN_CHECK: begin
                state_d = reject ? SPAWN_PICK : SPAWN_IDLE;
            end
            default: begin
                state_d = SPAWN_IDLE;
            end
        endcase
    end

    always_comb begin
        query_x = '0;
        query_y = '0;
        accept  = 1'b0;
        busy    = (state_q != SPAWN_IDLE);
        if (state_q == SPAWN_CHECK) begin
            query_x = cand_x_q;
            query_y = cand_y_q;
            accept  = !reject;
        end
    end

    // Clear wins over a simultaneous eat; otherwise count up and stick at max.
    always_comb begin
        score_d = score_q;
        if (score_reset) begin
            score_d = '0;
        end else if (eat && (score_q != {SCORE_W{1'b1}})) begin
            score_d = score_q + SCORE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            score_q <= '0;
        end else begin
            score_q <= score_d;
        end
    end

    assign score = score_q;

endmodule

// File: tb/tb_food_manager.sv
// Randomized scoreboard bench for food_manager: a slot/score model predicts
// every cycle, and each observed spawn is checked against the placement rules.
module tb_food_manager;

    localparam int GW   = 40;
    localparam int GH   = 30;
    localparam int XW   = 6;
    localparam int YW   = 5;
    localparam int NF   = 4;
    localparam int SW   = 8;
    localparam int SMAX = (1 << SW) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [XW-1:0]     head_x = '0;
    logic [YW-1:0]     head_y = '0;
    logic              score_reset = 1'b0;
    logic [XW-1:0]     query_x;
    logic [YW-1:0]     query_y;
    logic              query_occupied;
    logic [NF*XW-1:0]  food_x;
    logic [NF*YW-1:0]  food_y;
    logic [NF-1:0]     food_valid;
    logic              eat;
    logic [2:0]        eat_slot;
    logic [SW-1:0]     score;
    logic              busy;

    always #5 clk = ~clk;

    food_manager #(
        .GRID_W(GW), .GRID_H(GH), .X_W(XW), .Y_W(YW),
        .N_FOOD(NF), .SCORE_W(SW), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst(rst), .head_x(head_x), .head_y(head_y),
        .score_reset(score_reset), .query_x(query_x), .query_y(query_y),
        .query_occupied(query_occupied), .food_x(food_x), .food_y(food_y),
        .food_valid(food_valid), .eat(eat), .eat_slot(eat_slot),
        .score(score), .busy(busy)
    );

    // Static snake body plus a global "everything occupied" override.
    bit body [GH][GW];
    bit force_occ = 1'b0;
    int qx, qy;
    always_comb begin
        qx = int'(query_x);
        qy = int'(query_y);
        query_occupied = force_occ;
        if (qx < GW && qy < GH && body[qy][qx]) query_occupied = 1'b1;
    end

    typedef struct packed {
        logic [NF-1:0]    v;
        logic [NF*XW-1:0] fx;
        logic [NF*YW-1:0] fy;
        logic             e;
        logic [2:0]       s;
        logic [SW-1:0]    sc;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: slot table, score, edge count of each slot clearing.
    int m_x[NF], m_y[NF], clr_edge[NF];
    bit m_v[NF];
    int m_score, cyc, prev_hx, prev_hy;
    bit prev_force;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_true(input string name, input bit cond);
        check(name, 64'(cond), 64'd1);
    endtask

    always @(negedge clk) begin
        exp_t it;
        if (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            check("eat", 64'(eat), 64'(it.e));
            check("eat_slot", 64'(eat_slot), 64'(it.s));
            check("score", 64'(score), 64'(it.sc));
            check("food_valid", 64'(food_valid), 64'(it.v));
            check("food_x", 64'(food_x), 64'(it.fx));
            check("food_y", 64'(food_y), 64'(it.fy));
            $display("cycle %0d head=(%0d,%0d) eat=%0b slot=%0d score=%0d valid=%b",
                     cyc, head_x, head_y, eat, eat_slot, score, food_valid);
        end
    end

    task automatic model_reset();
        for (int i = 0; i < NF; i++) begin
            m_v[i]      = (i == 0);
            m_x[i]      = (i == 0) ? GW / 2 : 0;
            m_y[i]      = (i == 0) ? GH / 2 : 0;
            clr_edge[i] = 0;
        end
        m_score    = 0;
        cyc        = 0;
        prev_force = 1'b0;
    endtask

    task automatic push_expect(input bit e, input int s);
        exp_t it;
        it = '0;
        for (int i = 0; i < NF; i++) begin
            it.v[i]             = m_v[i];
            it.fx[i*XW +: XW]   = XW'(m_x[i]);
            it.fy[i*YW +: YW]   = YW'(m_y[i]);
        end
        it.e  = e;
        it.s  = 3'(s);
        it.sc = SW'(m_score);
        sb_q.push_back(it);
    endtask

    function automatic int pick_valid();
        int cands[$];
        for (int i = 0; i < NF; i++) if (m_v[i]) cands.push_back(i);
        if (cands.size() == 0) return -1;
        return cands[$urandom_range(cands.size() - 1)];
    endfunction

    function automatic bit all_valid();
        for (int i = 0; i < NF; i++) if (!m_v[i]) return 1'b0;
        return 1'b1;
    endfunction

    // One clock: absorb spawns from the edge just passed, drive, predict.
    task automatic step(input int hx, input int hy, input bit sr, input bit frc);
        int nnew;
        int ei;
        @(posedge clk);
        cyc++;
        #1;
        nnew = 0;
        for (int i = 0; i < NF; i++) begin
            if (!m_v[i] && food_valid[i]) begin
                int nx, ny;
                nx = int'(food_x[i*XW +: XW]);
                ny = int'(food_y[i*YW +: YW]);
                nnew++;
                check_true("spawn_in_grid", nx < GW && ny < GH);
                check_true("spawn_latency", (cyc - clr_edge[i]) >= 3);
                check_true("spawn_not_head", !(nx == prev_hx && ny == prev_hy));
                check_true("spawn_not_body", (nx < GW && ny < GH) ? !body[ny][nx] : 1'b1);
                check_true("spawn_while_blocked", !prev_force);
                for (int j = 0; j < NF; j++) begin
                    if (m_v[j] && m_x[j] == nx && m_y[j] == ny) check_true("spawn_distinct", 1'b0);
                end
                m_v[i] = 1'b1;
                m_x[i] = nx;
                m_y[i] = ny;
            end
        end
        if (nnew > 1) check("spawns_per_edge", 64'(nnew), 64'd1);
        head_x      = XW'(hx);
        head_y      = YW'(hy);
        score_reset = sr;
        force_occ   = frc;
        #1;
        ei = -1;
        for (int i = 0; i < NF; i++) begin
            if (ei < 0 && m_v[i] && m_x[i] == hx && m_y[i] == hy) ei = i;
        end
        push_expect(ei >= 0, (ei < 0) ? 0 : ei);
        if (ei >= 0) begin
            m_v[ei]      = 1'b0;
            clr_edge[ei] = cyc + 1;
        end
        if (sr) m_score = 0;
        else if (ei >= 0 && m_score < SMAX) m_score++;
        prev_hx    = hx;
        prev_hy    = hy;
        prev_force = frc;
    endtask

    task automatic park();
        step(GW - 1, GH - 1, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        head_x = XW'(GW - 1);
        head_y = YW'(GH - 1);
        score_reset = 1'b0;
        force_occ = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        push_expect(1'b0, 0);
        @(negedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_query", 64'({query_x, query_y}), 64'd0);
        prev_hx = GW - 1;
        prev_hy = GH - 1;
        rst = 1'b1;
    endtask

    task automatic fill(input string name);
        for (int k = 0; k < 1000 && !all_valid(); k++) park();
        check_true(name, all_valid());
    endtask

    task automatic eat_one();
        int ai;
        ai = pick_valid();
        if (ai >= 0) step(m_x[ai], m_y[ai], 1'b0, 1'b0);
        else park();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        for (int y = 0; y < GH; y++)
            for (int x = 0; x < GW; x++)
                body[y][x] = ($urandom_range(99) < 5);

        // Reset state, then initial fill of slots 1..3.
        do_reset();
        park();
        fill("initial_fill");

        // Single eat of slot 0, then refill.
        step(m_x[0], m_y[0], 1'b0, 1'b0);
        park();
        park();
        check("score_after_first_eat", 64'(score), 64'd1);
        fill("refill_slot0");

        // Occupancy blocked for 50 cycles: spawner stays busy, nothing fills.
        step(m_x[1], m_y[1], 1'b0, 1'b0);
        for (int k = 0; k < 50; k++) step(GW - 1, GH - 1, 1'b0, 1'b1);
        check("blocked_busy", 64'(busy), 64'd1);
        check("blocked_slot1_empty", 64'(food_valid[1]), 64'd0);
        fill("refill_after_unblock");

        // Saturation: clear, eat up to max, then a few more.
        step(GW - 1, GH - 1, 1'b1, 1'b0);
        for (int k = 0; k < 6000 && m_score < SMAX; k++) eat_one();
        check("reached_max", 64'(m_score), 64'(SMAX));
        for (int n = 0, k = 0; n < 5 && k < 200; k++) begin
            if (pick_valid() >= 0) n++;
            eat_one();
        end
        park();
        check("score_saturated", 64'(score), 64'(SMAX));
        fill("refill_after_saturation");

        // Eat and score clear on the same edge.
        begin
            int ai;
            ai = pick_valid();
            step(m_x[ai], m_y[ai], 1'b1, 1'b0);
            park();
            check("clear_beats_eat", 64'(score), 64'd0);
        end

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            int ai;
            ai = pick_valid();
            if (ai >= 0 && $urandom_range(99) < 40)
                step(m_x[ai], m_y[ai], ($urandom_range(99) < 5), 1'b0);
            else
                step($urandom_range(GW - 1), $urandom_range(GH - 1), ($urandom_range(99) < 5), 1'b0);
        end

        // Reset while the spawner is checking a candidate.
        fill("fill_before_midcheck");
        eat_one();
        found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            park();
            if (query_x != '0 || query_y != '0) found = 1'b1;
        end
        check_true("reached_check_state", found);
        if (found) begin
            void'(sb_q.pop_back());
            rst = 1'b0;
            #1;
            check("midreset_valid", 64'(food_valid), 64'd1);
            check("midreset_x", 64'(food_x), 64'(GW / 2));
            check("midreset_y", 64'(food_y), 64'(GH / 2));
            check("midreset_score", 64'(score), 64'd0);
            check("midreset_busy", 64'(busy), 64'd0);
            @(posedge clk);
            #1;
            check("midreset_no_write", 64'(food_valid), 64'd1);
            check("midreset_query", 64'({query_x, query_y}), 64'd0);
            do_reset();
            park();
            fill("fill_after_midreset");
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
